// File: rtl/ssc_link_partner_pkg.sv
// ssc_link_pkg: shared types and constants for the SSC link partner.
//   rx_state_t / tx_state_t : serial FSM state encodings
//   DATA_BITS               : bits per 8N1 character
//   DEFAULT_BAUD_DIV        : CLK_14M cycles per bit at 9600 baud
package ssc_link_pkg;

  localparam int DATA_BITS        = 8;
  localparam int DEFAULT_BAUD_DIV = 1491;

  // Literals carry an RX_ST_/TX_ST_ prefix so both enums can share this scope.
  typedef enum logic [2:0] {
    RX_ST_IDLE,
    RX_ST_START,
    RX_ST_DATA,
    RX_ST_STOP,
    RX_ST_BREAK_WAIT
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_ST_IDLE,
    TX_ST_HOLD,
    TX_ST_START,
    TX_ST_DATA,
    TX_ST_STOP
  } tx_state_t;

endpackage

// File: rtl/ssc_link_partner_if.sv
// ssc_link_partner_if: host-side byte stream of the SSC link partner.
//   TX_DATA/TX_VALID/TX_READY : bytes going out to the card
//   RX_DATA/RX_VALID/RX_READY : bytes received from the card (FIFO head)
//   RX_FRAME_ERR / RX_OVERRUN : one-cycle receive error pulses
// master = host side, slave = ssc_link_partner.
interface ssc_link_partner_if;
  import ssc_link_pkg::*;

  logic [DATA_BITS-1:0] TX_DATA;
  logic                 TX_VALID;
  logic                 TX_READY;
  logic [DATA_BITS-1:0] RX_DATA;
  logic                 RX_VALID;
  logic                 RX_READY;
  logic                 RX_FRAME_ERR;
  logic                 RX_OVERRUN;

  modport master (
    output TX_DATA, TX_VALID, RX_READY,
    input  TX_READY, RX_DATA, RX_VALID, RX_FRAME_ERR, RX_OVERRUN
  );

  modport slave (
    input  TX_DATA, TX_VALID, RX_READY,
    output TX_READY, RX_DATA, RX_VALID, RX_FRAME_ERR, RX_OVERRUN
  );

endinterface

// File: rtl/ssc_link_partner_rx_fifo.sv
// ssc_rx_fifo: synchronous receive FIFO with a registered head byte.
//   CLK_14M, RESET : clock, async active-high reset
//   push/push_data : write request from the RX deserializer
//   pop            : read request (ignored while empty)
//   head           : registered FIFO head, stable until a pop
//   not_empty      : head is valid
//   overrun        : one-cycle pulse when a push was dropped
//   count          : number of stored entries (0..DEPTH)
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module ssc_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                   CLK_14M,
  input  logic                   RESET,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   not_empty,
  output logic                   overrun,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    rd_next;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == CW'(DEPTH));
  assign not_empty = (count != '0);
  assign do_pop    = pop & not_empty;
  assign do_push   = push & (~full | do_pop);
  assign rd_next   = rd_ptr + PW'(1);

  // When full with a simultaneous pop, wr_ptr == rd_ptr; overwriting that slot
  // is safe because the departing byte already lives in the head register.
  always_ff @(posedge CLK_14M) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge CLK_14M or posedge RESET) begin
    if (RESET) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      head    <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= push & ~do_push;
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_next;

      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase

      // Head tracks mem[rd_ptr]; bypass the array when the FIFO is (or is
      // about to be) empty so a fresh byte appears without extra latency.
      if (do_pop) begin
        if (count > CW'(1))  head <= mem[rd_next];
        else if (do_push)    head <= push_data;
      end else if (do_push && (count == '0)) begin
        head <= push_data;
      end
    end
  end

endmodule

// File: rtl/ssc_link_partner.sv
// ssc_link_partner: 8N1 link partner for the Super Serial Card UART.
//   CLK_14M, RESET : sole clock, async active-high reset
//   host           : host-side byte stream (ssc_link_partner_if.slave)
//   SER_RXD        : from card TXD, idle high
//   SER_TXD        : to card RXD, idle high
//   SER_RTS_IN     : from card RTS, low = card may receive
//   SER_CTS_OUT    : to card CTS, low = we may receive
//
// RX FSM
//   state      | meaning
//   IDLE       | waiting for a falling edge on the synchronized line
//   START      | half a bit in; re-check start bit, reject glitches
//   DATA       | sampling 8 data bits LSB first, one per bit time
//   STOP       | sampling stop bit; push byte or flag framing error
//   BREAK_WAIT | line held low after a bad stop; wait for it to go high
//
// TX FSM
//   state | meaning
//   IDLE  | TX_READY high, waiting for a byte
//   HOLD  | byte latched, waiting for the card's RTS
//   START | driving start bit
//   DATA  | driving 8 data bits LSB first
//   STOP  | driving stop bit, then back to IDLE
module ssc_link_partner import ssc_link_pkg::*; #(
  parameter int BAUD_DIV   = DEFAULT_BAUD_DIV,
  parameter int FIFO_DEPTH = 16,
  parameter int CTS_SLACK  = 4
) (
  input  logic                 CLK_14M,
  input  logic                 RESET,
  ssc_link_partner_if.slave    host,
  input  logic                 SER_RXD,
  output logic                 SER_TXD,
  input  logic                 SER_RTS_IN,
  output logic                 SER_CTS_OUT
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;

  // Down-counters expire at zero, so loads are one less than the interval.
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

  logic rxd_meta, rxd_sync, rxd_prev;
  logic rts_meta, rts_sync;

  always_ff @(posedge CLK_14M or posedge RESET) begin
    if (RESET) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
      rts_meta <= 1'b1;
      rts_sync <= 1'b1;
    end else begin
      rxd_meta <= SER_RXD;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
      rts_meta <= SER_RTS_IN;
      rts_sync <= rts_meta;
    end
  end

  // ---------------- RX ----------------
  rx_state_t            rx_state;
  logic [CNT_W-1:0]     rx_cnt;
  logic [BIT_W-1:0]     rx_bit;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_frame_err;
  logic                 rx_push;

  // Push straight from the stop-bit sample so RX_VALID rises on the next cycle.
  assign rx_push = (rx_state == RX_ST_STOP) && (rx_cnt == '0) && rxd_sync;

  always_ff @(posedge CLK_14M or posedge RESET) begin
    if (RESET) begin
      rx_state     <= RX_ST_IDLE;
      rx_cnt       <= '0;
      rx_bit       <= '0;
      rx_shift     <= '0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_frame_err <= 1'b0;
      case (rx_state)
        RX_ST_IDLE: begin
          if (rxd_prev && !rxd_sync) begin
            rx_state <= RX_ST_START;
            rx_cnt   <= HALF_LOAD;
          end
        end
        RX_ST_START: begin
          if (rx_cnt == '0) begin
            if (rxd_sync) begin
              rx_state <= RX_ST_IDLE;
            end else begin
              rx_state <= RX_ST_DATA;
              rx_cnt   <= BIT_LOAD;
              rx_bit   <= '0;
            end
          end else begin
            rx_cnt <= rx_cnt - CNT_W'(1);
          end
        end
        RX_ST_DATA: begin
          if (rx_cnt == '0) begin
            rx_shift <= {rxd_sync, rx_shift[DATA_BITS-1:1]};
            rx_cnt   <= BIT_LOAD;
            if (rx_bit == LAST_BIT) rx_state <= RX_ST_STOP;
            else                    rx_bit   <= rx_bit + BIT_W'(1);
          end else begin
            rx_cnt <= rx_cnt - CNT_W'(1);
          end
        end
        RX_ST_STOP: begin
          if (rx_cnt == '0) begin
            if (rxd_sync) begin
              rx_state <= RX_ST_IDLE;
            end else begin
              rx_frame_err <= 1'b1;
              rx_state     <= RX_ST_BREAK_WAIT;
            end
          end else begin
            rx_cnt <= rx_cnt - CNT_W'(1);
          end
        end
        RX_ST_BREAK_WAIT: begin
          if (rxd_sync) rx_state <= RX_ST_IDLE;
        end
        default: rx_state <= RX_ST_IDLE;
      endcase
    end
  end

  logic [CW-1:0] fifo_count;
  logic [CW-1:0] fifo_free;

  ssc_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_rx_fifo (
    .CLK_14M   (CLK_14M),
    .RESET     (RESET),
    .push      (rx_push),
    .push_data (rx_shift),
    .pop       (host.RX_READY),
    .head      (host.RX_DATA),
    .not_empty (host.RX_VALID),
    .overrun   (host.RX_OVERRUN),
    .count     (fifo_count)
  );

  assign host.RX_FRAME_ERR = rx_frame_err;
  assign fifo_free         = CW'(FIFO_DEPTH) - fifo_count;

  always_ff @(posedge CLK_14M or posedge RESET) begin
    if (RESET) SER_CTS_OUT <= 1'b0;
    else       SER_CTS_OUT <= (fifo_free <= CW'(CTS_SLACK));
  end

  // ---------------- TX ----------------
  tx_state_t            tx_state;
  logic [CNT_W-1:0]     tx_cnt;
  logic [BIT_W-1:0]     tx_bit;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_ready;

  assign host.TX_READY = tx_ready;

  always_ff @(posedge CLK_14M or posedge RESET) begin
    if (RESET) begin
      tx_state <= TX_ST_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_ready <= 1'b1;
      SER_TXD  <= 1'b1;
    end else begin
      case (tx_state)
        TX_ST_IDLE: begin
          if (host.TX_VALID && tx_ready) begin
            tx_shift <= host.TX_DATA;
            tx_ready <= 1'b0;
            tx_state <= TX_ST_HOLD;
          end
        end
        // RTS is only honoured here; once a frame starts it always completes.
        TX_ST_HOLD: begin
          if (!rts_sync) begin
            SER_TXD  <= 1'b0;
            tx_cnt   <= BIT_LOAD;
            tx_state <= TX_ST_START;
          end
        end
        TX_ST_START: begin
          if (tx_cnt == '0) begin
            SER_TXD  <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
            tx_bit   <= '0;
            tx_cnt   <= BIT_LOAD;
            tx_state <= TX_ST_DATA;
          end else begin
            tx_cnt <= tx_cnt - CNT_W'(1);
          end
        end
        TX_ST_DATA: begin
          if (tx_cnt == '0) begin
            tx_cnt <= BIT_LOAD;
            if (tx_bit == LAST_BIT) begin
              SER_TXD  <= 1'b1;
              tx_state <= TX_ST_STOP;
            end else begin
              SER_TXD  <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
              tx_bit   <= tx_bit + BIT_W'(1);
            end
          end else begin
            tx_cnt <= tx_cnt - CNT_W'(1);
          end
        end
        TX_ST_STOP: begin
          if (tx_cnt == '0) begin
            tx_ready <= 1'b1;
            tx_state <= TX_ST_IDLE;
          end else begin
            tx_cnt <= tx_cnt - CNT_W'(1);
          end
        end
        default: tx_state <= TX_ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ssc_link_partner.sv
// Directed bench for ssc_link_partner at BAUD_DIV = 16.
module tb_ssc_link_partner;

  localparam int B = 16;

  logic clk = 1'b0;
  logic rst;
  logic ser_rxd;
  logic ser_txd;
  logic ser_rts;
  logic ser_cts;

  int n_checks = 0;
  int n_pass   = 0;
  int fe_cnt   = 0;
  int ov_cnt   = 0;

  ssc_link_partner_if bus ();

  ssc_link_partner #(
    .BAUD_DIV   (B),
    .FIFO_DEPTH (16),
    .CTS_SLACK  (4)
  ) dut (
    .CLK_14M     (clk),
    .RESET       (rst),
    .host        (bus),
    .SER_RXD     (ser_rxd),
    .SER_TXD     (ser_txd),
    .SER_RTS_IN  (ser_rts),
    .SER_CTS_OUT (ser_cts)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.RX_FRAME_ERR) fe_cnt++;
    if (bus.RX_OVERRUN)   ov_cnt++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", n_pass, n_checks);
    $fatal(1);
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_val, input int stop_bits);
    ser_rxd = 1'b0;
    tick(B);
    for (int i = 0; i < 8; i++) begin
      ser_rxd = b[i];
      tick(B);
    end
    ser_rxd = stop_val;
    tick(B * stop_bits);
    ser_rxd = 1'b1;
  endtask

  task automatic pop_one();
    bus.RX_READY = 1'b1;
    tick(1);
    bus.RX_READY = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    n_checks++; if (ser_txd !== 1'b1) $display("FAIL reset_txd got %b want 1", ser_txd); else n_pass++;
    n_checks++; if (bus.TX_READY !== 1'b1) $display("FAIL reset_tx_ready got %b want 1", bus.TX_READY); else n_pass++;
    n_checks++; if (bus.RX_VALID !== 1'b0) $display("FAIL reset_rx_valid got %b want 0", bus.RX_VALID); else n_pass++;
    n_checks++; if (bus.RX_DATA !== 8'h00) $display("FAIL reset_rx_data got %h want 00", bus.RX_DATA); else n_pass++;
    n_checks++; if (bus.RX_FRAME_ERR !== 1'b0) $display("FAIL reset_frame_err got %b want 0", bus.RX_FRAME_ERR); else n_pass++;
    n_checks++; if (bus.RX_OVERRUN !== 1'b0) $display("FAIL reset_overrun got %b want 0", bus.RX_OVERRUN); else n_pass++;
    n_checks++; if (ser_cts !== 1'b0) $display("FAIL reset_cts got %b want 0", ser_cts); else n_pass++;
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_tx_frame();
    logic [9:0] frame;
    frame = {1'b1, 8'hA5, 1'b0};
    ser_rts = 1'b0;
    tick(3);
    bus.TX_DATA  = 8'hA5;
    bus.TX_VALID = 1'b1;
    tick(1);
    bus.TX_VALID = 1'b0;
    n_checks++; if (bus.TX_READY !== 1'b0) $display("FAIL tx_ready_after_hs got %b want 0", bus.TX_READY); else n_pass++;
    n_checks++; if (ser_txd !== 1'b1) $display("FAIL tx_hold_idle got %b want 1", ser_txd); else n_pass++;
    tick(1);
    for (int k = 0; k < 10; k++) begin
      tick(B / 2);
      n_checks++;
      if (ser_txd !== frame[k]) $display("FAIL tx_bit%0d got %b want %b", k, ser_txd, frame[k]);
      else n_pass++;
      if (k == 9) begin
        n_checks++;
        if (bus.TX_READY !== 1'b0) $display("FAIL tx_ready_in_stop got %b want 0", bus.TX_READY);
        else n_pass++;
      end
      tick(B / 2);
    end
    n_checks++; if (bus.TX_READY !== 1'b1) $display("FAIL tx_ready_return got %b want 1", bus.TX_READY); else n_pass++;
  endtask

  task automatic test_tx_flow();
    logic stayed_idle;
    int   lat;
    int   waited;
    ser_rts = 1'b1;
    tick(3);
    bus.TX_DATA  = 8'h3C;
    bus.TX_VALID = 1'b1;
    tick(1);
    bus.TX_VALID = 1'b0;
    stayed_idle = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (ser_txd !== 1'b1) stayed_idle = 1'b0;
      tick(1);
    end
    n_checks++; if (stayed_idle !== 1'b1) $display("FAIL flow_txd_idle got %b want 1", stayed_idle); else n_pass++;
    n_checks++; if (bus.TX_READY !== 1'b0) $display("FAIL flow_tx_ready got %b want 0", bus.TX_READY); else n_pass++;
    ser_rts = 1'b0;
    lat = 0;
    for (int i = 1; i <= 5; i++) begin
      tick(1);
      if (lat == 0 && ser_txd === 1'b0) lat = i;
    end
    n_checks++;
    if (lat < 1 || lat > 3) $display("FAIL flow_start_latency got %0d cycles want 1..3", lat);
    else n_pass++;
    // Card drops RTS mid-frame: the frame must still complete.
    tick(40);
    ser_rts = 1'b1;
    waited = 0;
    while (bus.TX_READY !== 1'b1 && waited < 200) begin
      tick(1);
      waited++;
    end
    n_checks++;
    if (bus.TX_READY !== 1'b1) $display("FAIL flow_frame_complete got ready=%b want 1 within 200 cycles", bus.TX_READY);
    else n_pass++;
  endtask

  task automatic test_reset_midframe();
    ser_rts = 1'b0;
    tick(3);
    bus.TX_DATA  = 8'h00;
    bus.TX_VALID = 1'b1;
    tick(1);
    bus.TX_VALID = 1'b0;
    tick(40);
    n_checks++; if (ser_txd !== 1'b0) $display("FAIL midframe_txd_low got %b want 0", ser_txd); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (ser_txd !== 1'b1) $display("FAIL midframe_async_txd got %b want 1", ser_txd); else n_pass++;
    n_checks++; if (bus.TX_READY !== 1'b1) $display("FAIL midframe_async_ready got %b want 1", bus.TX_READY); else n_pass++;
    tick(2);
    rst = 1'b0;
    tick(3);
  endtask

  task automatic test_rx_basic();
    int fe0;
    send_rx(8'h5A, 1'b1, 1);
    tick(2);
    n_checks++; if (bus.RX_VALID !== 1'b1) $display("FAIL rx_valid got %b want 1", bus.RX_VALID); else n_pass++;
    n_checks++; if (bus.RX_DATA !== 8'h5A) $display("FAIL rx_data got %h want 5a", bus.RX_DATA); else n_pass++;
    pop_one();
    n_checks++; if (bus.RX_VALID !== 1'b0) $display("FAIL rx_pop_empty got %b want 0", bus.RX_VALID); else n_pass++;
    fe0 = fe_cnt;
    ser_rxd = 1'b0;
    tick(8);
    ser_rxd = 1'b1;
    tick(3 * B);
    n_checks++; if (bus.RX_VALID !== 1'b0) $display("FAIL glitch_no_byte got %b want 0", bus.RX_VALID); else n_pass++;
    n_checks++; if (fe_cnt != fe0) $display("FAIL glitch_no_err got %0d pulses want 0", fe_cnt - fe0); else n_pass++;
  endtask

  task automatic test_rx_frame_err();
    int fe0;
    fe0 = fe_cnt;
    send_rx(8'h81, 1'b0, 40);
    tick(2 * B);
    n_checks++; if (fe_cnt - fe0 != 1) $display("FAIL frame_err_pulses got %0d want 1", fe_cnt - fe0); else n_pass++;
    n_checks++; if (bus.RX_VALID !== 1'b0) $display("FAIL frame_err_discard got %b want 0", bus.RX_VALID); else n_pass++;
    send_rx(8'h11, 1'b1, 1);
    tick(2);
    n_checks++; if (bus.RX_VALID !== 1'b1) $display("FAIL after_err_valid got %b want 1", bus.RX_VALID); else n_pass++;
    n_checks++; if (bus.RX_DATA !== 8'h11) $display("FAIL after_err_data got %h want 11", bus.RX_DATA); else n_pass++;
    pop_one();
    tick(2);
  endtask

  task automatic test_fifo_cts();
    int ov0;
    for (int i = 0; i < 16; i++) begin
      send_rx(8'(i), 1'b1, 1);
      tick(2);
      if (i == 10) begin
        n_checks++;
        if (ser_cts !== 1'b0) $display("FAIL cts_after_11 got %b want 0", ser_cts);
        else n_pass++;
      end
      if (i == 11) begin
        n_checks++;
        if (ser_cts !== 1'b1) $display("FAIL cts_after_12 got %b want 1", ser_cts);
        else n_pass++;
      end
    end
    ov0 = ov_cnt;
    send_rx(8'hEE, 1'b1, 1);
    tick(2);
    n_checks++; if (ov_cnt - ov0 != 1) $display("FAIL overrun_pulses got %0d want 1", ov_cnt - ov0); else n_pass++;
    n_checks++; if (bus.RX_DATA !== 8'h00) $display("FAIL full_head got %h want 00", bus.RX_DATA); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (bus.RX_VALID !== 1'b1 || bus.RX_DATA !== 8'(i))
        $display("FAIL drain_%0d got valid=%b data=%h want valid=1 data=%h", i, bus.RX_VALID, bus.RX_DATA, 8'(i));
      else n_pass++;
      pop_one();
    end
    tick(2);
    n_checks++; if (bus.RX_VALID !== 1'b0) $display("FAIL drain_empty got %b want 0", bus.RX_VALID); else n_pass++;
    n_checks++; if (ser_cts !== 1'b0) $display("FAIL drain_cts got %b want 0", ser_cts); else n_pass++;
  endtask

  initial begin
    rst          = 1'b1;
    ser_rxd      = 1'b1;
    ser_rts      = 1'b1;
    bus.TX_DATA  = 8'h00;
    bus.TX_VALID = 1'b0;
    bus.RX_READY = 1'b0;
    #1;
    test_reset();
    test_tx_frame();
    test_tx_flow();
    test_reset_midframe();
    test_rx_basic();
    test_rx_frame_err();
    test_fifo_cts();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ssc_link_partner.md
# ssc_link_partner

Framework-side serial endpoint that sits on the far end of the Super Serial Card's UART pins and acts as its link partner. It receives 8N1 frames on the card's TXD line into a small RX FIFO, transmits 8N1 frames onto the card's RXD line, and implements the RTS/CTS hardware handshake. Line rate matches the card's fixed DIP setting of 9600 baud, 8 data bits, 1 stop bit, no parity. It connects the card to the host-side byte stream (HPS bridge or loopback test harness).

## Interface
- BAUD_DIV, 1491: CLK_14M cycles per bit (14.31818 MHz / 9600). Legal values are 16 and above.
- FIFO_DEPTH, 16: RX FIFO entries. Must be a power of 2.
- CTS_SLACK, 4: CTS deasserts when free entries ≤ CTS_SLACK.

Ports:
- CLK_14M  in  1  sole clock.
- RESET  in  1  asynchronous, active-high.
- TX_DATA  in  8  byte to send to the card.
- TX_VALID  in  1  TX_DATA valid.
- TX_READY  out  1  byte accepted on a cycle with TX_VALID & TX_READY.
- RX_DATA  out  8  FIFO head byte.
- RX_VALID  out  1  FIFO not empty.
- RX_READY  in  1  pop head on a cycle with RX_VALID & RX_READY.
- RX_FRAME_ERR  out  1  one-cycle pulse on a bad stop bit.
- RX_OVERRUN  out  1  one-cycle pulse when a byte is dropped because the FIFO is full.
- SER_RXD  in  1  from card UART_TXD. Idle level is high.
- SER_TXD  out  1  to card UART_RXD. Idle level is high.
- SER_RTS_IN  in  1  from card UART_RTS. Active low: the card is ready to receive.
- SER_CTS_OUT  out  1  to card UART_CTS. Active low: we can accept data.

## Operation
- SER_RXD and SER_RTS_IN each pass through a 2-flop synchronizer. On reset, both synchronizers load 1.
- RX FSM states:
  - IDLE: a synchronized falling edge moves to START and loads the bit counter with BAUD_DIV/2.
  - START: at counter expiry, re-sample the line. If high, this is a false start; return to IDLE. If low, go to DATA and load BAUD_DIV.
  - DATA: sample 8 bits, LSB first, one every BAUD_DIV cycles.
  - STOP: sample the stop bit.
    - Stop bit high: push the byte, then return to IDLE.
    - Stop bit low: pulse RX_FRAME_ERR, discard the byte, and go to BREAK_WAIT.
  - BREAK_WAIT: stay until the line is high, then go to IDLE.
- Push into a full FIFO: pulse RX_OVERRUN and drop the new byte.
  - Exception: if a pop happens in the same cycle, the push is accepted.
- Push and pop in the same cycle on a non-full FIFO: the count is unchanged.
- SER_CTS_OUT = 1 when (FIFO_DEPTH − count) ≤ CTS_SLACK, otherwise 0. It is registered.
- TX FSM states:
  - IDLE: TX_READY = 1. On handshake, latch TX_DATA and go to HOLD.
  - HOLD: wait until the synchronized RTS is 0, then go to START.
  - START: drive 0 for BAUD_DIV cycles.
  - DATA: drive 8 bits, LSB first, BAUD_DIV cycles each.
  - STOP: drive 1 for BAUD_DIV cycles, then go to IDLE.
- RTS deasserting mid-frame does not abort the frame. RTS is checked only in HOLD.
- RX and TX run fully independently and full-duplex.

## Timing
- Reset values of outputs:
  - SER_TXD = 1
  - TX_READY = 1 (TX in IDLE)
  - RX_VALID = 0
  - RX_DATA = 0
  - RX_FRAME_ERR = 0
  - RX_OVERRUN = 0
  - SER_CTS_OUT = 0
- Reset asserted mid-frame: both FSMs return to IDLE immediately, the FIFO empties, and SER_TXD returns to 1 asynchronously.
- TX latency:
  - With synchronized RTS already 0: SER_TXD falls 2 cycles after the handshake edge (one cycle in HOLD).
  - The frame lasts exactly 10·BAUD_DIV cycles.
  - TX_READY rises the cycle after the stop bit ends.
- RX latency:
  - The data sample point is BAUD_DIV/2 after the detected start edge, plus 2 synchronizer cycles.
  - RX_VALID rises 1 cycle after the stop-bit sample.
- RX_DATA is FIFO-head registered output and is stable while RX_VALID & !RX_READY.
- Counter widths: bit counter is $clog2(BAUD_DIV); FIFO pointers are $clog2(FIFO_DEPTH). Pointers wrap modulo FIFO_DEPTH. The count is one bit wider than the pointers.

## Structure
- Package ssc_link_pkg holds:
  - rx_state_t {IDLE, START, DATA, STOP, BREAK_WAIT}
  - tx_state_t {IDLE, HOLD, START, DATA, STOP}
  - constants DATA_BITS = 8, DEFAULT_BAUD_DIV = 1491
- One sub-module, ssc_rx_fifo: a synchronous FIFO with registered head, a count output, and simultaneous push/pop when full.
- The top level holds both FSMs, the synchronizers, and the CTS register.

## Test plan
- Bench uses BAUD_DIV = 16.
- TX: send 0xA5 with RTS = 0 → SER_TXD carries 0,1,0,1,0,0,1,0,1,1 at 16 cycles each; TX_READY returns high after 160 cycles.
- TX flow control: hold RTS = 1, offer 0x3C → TX_READY low, SER_TXD stays 1 indefinitely. Release RTS → frame starts within 3 cycles.
- RX: drive frame 0x5A on SER_RXD → RX_VALID = 1 with RX_DATA = 0x5A. Also drive an 8-cycle low glitch → no byte, no error.
- RX frame error: send 0x81 with stop bit = 0 held for 40 bit-times → one RX_FRAME_ERR pulse, FIFO stays empty, and the next valid frame 0x11 is received.
- FIFO/CTS: send 16 bytes with RX_READY = 0 → SER_CTS_OUT goes 1 after the 12th byte; a 17th byte pulses RX_OVERRUN. Then drain → bytes 0..15 come out in order and CTS returns to 0.
